// File: rtl/csk_adder_pipe_if.sv
// csk_adder_pipe_if: operand/result handshake bundle for the pipelined carry-skip adder
interface csk_adder_pipe_if #(
  parameter int WIDTH = 16
);
  logic in_valid, in_ready, cin, sub;
  logic [WIDTH-1:0] inA, inB, sum;
  logic out_valid, out_ready, cout, ovf;
  modport master (
    output in_valid, inA, inB, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );
  modport slave (
    input  in_valid, inA, inB, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/csk_adder_pipe_block.sv
// csk_block: BLK-bit ripple block whose carry-out bypasses the chain when every bit propagates
module csk_block #(
  parameter int BLK = 4
) (
  input  logic [BLK-1:0] a,
  input  logic [BLK-1:0] b,
  input  logic           cin,
  output logic [BLK-1:0] s,
  output logic           cout,
  output logic           cm
);
  logic [BLK:0] c;
  assign c[0] = cin;
  for (genvar i = 0; i < BLK; i++) begin : r
    assign c[i+1] = (a[i] & b[i]) | ((a[i] ^ b[i]) & c[i]);
  end
  assign s    = a ^ b ^ c[BLK-1:0];
  assign cout = &(a ^ b) ? cin : c[BLK];
  assign cm   = c[BLK-1];
endmodule

// File: rtl/csk_adder_pipe.sv
// csk_adder_pipe: carry-skip add/sub split into PIPE register stages behind a valid/ready handshake
module csk_adder_pipe #(
  parameter int WIDTH = 16,
  parameter int BLK   = 4,
  parameter int PIPE  = 2
) (
  input logic clk,
  input logic rst_n,
  csk_adder_pipe_if.slave bus
);
  localparam int NB  = WIDTH / BLK;
  localparam int BPS = NB / PIPE;
  localparam int SW  = BPS * BLK;
  logic en, m_q;
  logic [WIDTH-1:0] bs;
  logic [NB-1:0] bci, bco, bcm;
  assign en = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = en;
  for (genvar k = 0; k < PIPE; k++) begin : st
    localparam logic [WIDTH-1:0] MK = ({WIDTH{1'b1}} >> (WIDTH - SW)) << (k * SW);
    logic [WIDTH-1:0] ai, bi, si, a_q, b_q, s_q;
    logic ci, vi, c_q, v_q;
    if (k == 0) begin : h
      assign ai = bus.inA;
      assign bi = bus.sub ? ~bus.inB : bus.inB;
      assign si = '0;
      assign ci = bus.sub | bus.cin;
      assign vi = bus.in_valid;
    end else begin : h
      assign ai = st[k-1].a_q;
      assign bi = st[k-1].b_q;
      assign si = st[k-1].s_q;
      assign ci = st[k-1].c_q;
      assign vi = st[k-1].v_q;
    end
    for (genvar j = 0; j < BPS; j++) begin : bk
      localparam int G = k * BPS + j;
      if (j == 0) begin : c
        assign bci[G] = ci;
      end else begin : c
        assign bci[G] = bco[G-1];
      end
      csk_block #(.BLK(BLK)) u_blk (
        .a(ai[G*BLK +: BLK]), .b(bi[G*BLK +: BLK]), .cin(bci[G]),
        .s(bs[G*BLK +: BLK]), .cout(bco[G]), .cm(bcm[G])
      );
    end
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        a_q <= '0;
        b_q <= '0;
        s_q <= '0;
        c_q <= 1'b0;
        v_q <= 1'b0;
      end else if (en) begin
        a_q <= ai;
        b_q <= bi;
        s_q <= (si & ~MK) | (bs & MK);
        c_q <= bco[(k+1)*BPS-1];
        v_q <= vi;
      end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) m_q <= 1'b0;
    else if (en) m_q <= bcm[NB-1];
  assign bus.out_valid = st[PIPE-1].v_q;
  assign bus.sum       = st[PIPE-1].s_q;
  assign bus.cout      = st[PIPE-1].c_q;
  assign bus.ovf       = st[PIPE-1].c_q ^ m_q;
endmodule

// File: tb/tb_csk_adder_pipe.sv
// tb_csk_adder_pipe: directed checks on the default build plus randomised scoreboarding of four builds
module tb_csk_adder_pipe;
  localparam int BL[4] = '{4, 4, 2, 16};
  localparam int PP[4] = '{2, 1, 4, 1};
  logic clk = 1'b0, rst_n = 1'b0, iv = 1'b0, cin = 1'b0, sub = 1'b0;
  logic [15:0] ina = '0, inb = '0;
  logic [3:0] ordy = '1, ir, ov, co, of;
  logic [3:0][15:0] sm;
  logic [17:0] q[4][$];
  int n_a = 0, n_f = 0;

  always #5 clk = ~clk;

  for (genvar d = 0; d < 4; d++) begin : g
    csk_adder_pipe_if #(.WIDTH(16)) bus ();
    assign bus.in_valid  = iv;
    assign bus.inA       = ina;
    assign bus.inB       = inb;
    assign bus.cin       = cin;
    assign bus.sub       = sub;
    assign bus.out_ready = ordy[d];
    assign ir[d] = bus.in_ready;
    assign ov[d] = bus.out_valid;
    assign sm[d] = bus.sum;
    assign co[d] = bus.cout;
    assign of[d] = bus.ovf;
    csk_adder_pipe #(.WIDTH(16), .BLK(BL[d]), .PIPE(PP[d])) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
    );
  end

  function automatic logic [17:0] model(logic [15:0] a, logic [15:0] b, logic c, logic s);
    logic [15:0] bb;
    logic [16:0] r;
    logic v;
    bb = s ? ~b : b;
    r  = {1'b0, a} + {1'b0, bb} + 17'(s | c);
    v  = (a[15] == bb[15]) && (r[15] != a[15]);
    return {r[16], v, r[15:0]};
  endfunction

  task automatic chk(input string t, input logic [31:0] o, input logic [31:0] e);
    n_a++;
    assert (o === e) else begin
      n_f++;
      $error("FAIL %s observed=%0h expected=%0h", t, o, e);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] b, input logic c, input logic s);
    iv = v; ina = a; inb = b; cin = c; sub = s;
  endtask

  task automatic out0(input string t, input logic [15:0] s, input logic c, input logic o);
    chk({t, "_valid"}, 32'(ov[0]), 32'd1);
    chk({t, "_sum"}, 32'(sm[0]), 32'(s));
    chk({t, "_cout"}, 32'(co[0]), 32'(c));
    chk({t, "_ovf"}, 32'(of[0]), 32'(o));
  endtask

  task automatic single(input string t, input logic [15:0] a, input logic [15:0] b, input logic c,
                        input logic s, input logic [15:0] es, input logic ec, input logic eo);
    drive(1'b1, a, b, c, s);
    tick;
    iv = 1'b0;
    chk({t, "_lat1"}, 32'(ov[0]), 32'd0);
    tick;
    out0(t, es, ec, eo);
  endtask

  task automatic sb;
    logic [17:0] e;
    for (int d = 0; d < 4; d++) begin
      if (iv && ir[d]) q[d].push_back(model(ina, inb, cin, sub));
      if (ov[d] && ordy[d]) begin
        chk($sformatf("rnd%0d_expected_beat", d), 32'(q[d].size() != 0), 32'd1);
        if (q[d].size() != 0) begin
          e = q[d].pop_front();
          chk($sformatf("rnd%0d_result", d), 32'({co[d], of[d], sm[d]}), 32'(e));
        end
      end
    end
  endtask

  initial begin
    #2;
    chk("rst_valid", 32'(ov[0]), 32'd0);
    chk("rst_sum", 32'(sm[0]), 32'd0);
    chk("rst_cout", 32'(co[0]), 32'd0);
    chk("rst_ovf", 32'(of[0]), 32'd0);
    #10 rst_n = 1'b1;
    tick;
    chk("rst_in_ready", 32'(ir[0]), 32'd1);
    single("fp_ffff", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    single("fp_aaaa", 16'hAAAA, 16'h5555, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    single("sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    single("sub_neg", 16'h0000, 16'h0001, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0);
    tick;
    chk("idle_valid", 32'(ov[0]), 32'd0);
    drive(1'b1, 16'h0001, 16'h0002, 1'b0, 1'b0);
    tick;
    chk("strm_lat", 32'(ov[0]), 32'd0);
    drive(1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b0);
    tick;
    out0("strm1", 16'h0003, 1'b0, 1'b0);
    drive(1'b1, 16'h1234, 16'h4321, 1'b0, 1'b0);
    tick;
    out0("strm2", 16'h8000, 1'b0, 1'b1);
    iv = 1'b0;
    tick;
    out0("strm3", 16'h5555, 1'b0, 1'b0);
    tick;
    chk("strm_end", 32'(ov[0]), 32'd0);
    ordy = '0;
    drive(1'b1, 16'h0001, 16'h0002, 1'b0, 1'b0);
    tick;
    drive(1'b1, 16'h0010, 16'h0020, 1'b0, 1'b0);
    tick;
    iv = 1'b0;
    for (int i = 0; i < 4; i++) begin
      out0($sformatf("bp_hold%0d", i), 16'h0003, 1'b0, 1'b0);
      chk($sformatf("bp_in_ready%0d", i), 32'(ir[0]), 32'd0);
      if (i < 3) tick;
    end
    ordy = '1;
    #1;
    chk("bp_rel_ready", 32'(ir[0]), 32'd1);
    tick;
    out0("bp_next", 16'h0030, 1'b0, 1'b0);
    tick;
    chk("bp_no_dup", 32'(ov[0]), 32'd0);
    drive(1'b1, 16'h00FF, 16'h0001, 1'b0, 1'b0);
    tick;
    iv = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mrst1_valid", 32'(ov[0]), 32'd0);
    chk("mrst1_sum", 32'(sm[0]), 32'd0);
    chk("mrst1_cout", 32'(co[0]), 32'd0);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk($sformatf("mrst1_quiet%0d", i), 32'(ov[0]), 32'd0);
    end
    ordy = '0;
    drive(1'b1, 16'h00FF, 16'h0001, 1'b0, 1'b0);
    tick;
    iv = 1'b0;
    tick;
    out0("mrst2_pre", 16'h0100, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst2_valid", 32'(ov[0]), 32'd0);
    chk("mrst2_sum", 32'(sm[0]), 32'd0);
    chk("mrst2_cout", 32'(co[0]), 32'd0);
    chk("mrst2_ovf", 32'(of[0]), 32'd0);
    ordy = '1;
    #2 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk($sformatf("mrst2_quiet%0d", i), 32'(ov[0]), 32'd0);
    end
    for (int c = 0; c < 18000; c++) begin
      iv  = $urandom_range(0, 3) != 0;
      ina = 16'($urandom);
      inb = 16'($urandom);
      cin = 1'($urandom);
      sub = 1'($urandom);
      for (int d = 0; d < 4; d++) ordy[d] = $urandom_range(0, 3) != 0;
      @(negedge clk);
      sb;
      tick;
    end
    iv = 1'b0;
    ordy = '1;
    repeat (8) begin
      @(negedge clk);
      sb;
      tick;
    end
    for (int d = 0; d < 4; d++) chk($sformatf("drain%0d", d), 32'(q[d].size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_a, n_f);
    $finish;
  end
endmodule
